writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 9 +
 rtl/wbq_fifo.sv | 46 ++++
 rtl/writeback_queue.sv | 101 ++++++++++
 3 files changed

// File: rtl/writeback_queue_pkg.sv
// writeback_queue_pkg: shared CPU register-file constants used by the writeback queue
package writeback_queue_pkg;
    localparam int REG_AW = 5;
    localparam int REG_N = 32;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    function automatic logic reg_live(input logic [REG_AW-1:0] r);
        return r != ZERO_REG;
    endfunction
endpackage

// File: rtl/wbq_fifo.sv
// wbq_fifo: circular entry storage with pointers, occupancy count and full/empty flags
module wbq_fifo
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [REG_AW-1:0]          in_reg,
    input  logic [DW-1:0]              in_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH)-1:0]   rptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic [REG_AW-1:0]          regs [DEPTH],
    output logic [DW-1:0]              datas [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0] wptr;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // pointer/count bookkeeping; flush and reset both empty the queue
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= push ? wptr + 1'b1 : wptr;
            rptr <= pop ? rptr + 1'b1 : rptr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // entry payload storage; validity is tracked by count, so no reset needed
    always_ff @(posedge clock) begin
        if (push) begin
            regs[wptr] <= in_reg;
            datas[wptr] <= in_data;
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: in-order register writeback buffer with forwarding search and registered output stage
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DW-1:0]     wb_data,
    input  logic              flush,
    output logic              RegWrite,
    output logic [REG_AW-1:0] write_reg,
    output logic [DW-1:0]     write_data,
    input  logic [REG_AW-1:0] read_reg1,
    input  logic [REG_AW-1:0] read_reg2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DW-1:0]     fwd_data1,
    output logic [DW-1:0]     fwd_data2,
    output logic              busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [REG_AW-1:0] regs [DEPTH];
    logic [DW-1:0]     datas [DEPTH];
    logic [PW-1:0]     idx;

    assign wb_ready = !full;
    assign push = wb_valid && wb_ready && reg_live(wb_reg) && !flush;
    assign pop = !empty && !flush;
    assign busy = !empty || RegWrite;

    wbq_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(flush),
        .in_reg(wb_reg),
        .in_data(wb_data),
        .full(full),
        .empty(empty),
        .rptr(rptr),
        .count(count),
        .regs(regs),
        .datas(datas)
    );

    // output stage: issue the head each cycle it exists; a flush cancels the next issue
    always_ff @(posedge clock) begin
        if (reset) begin
            RegWrite <= 1'b0;
            write_reg <= '0;
            write_data <= '0;
        end else if (pop) begin
            RegWrite <= 1'b1;
            write_reg <= regs[rptr];
            write_data <= datas[rptr];
        end else begin
            RegWrite <= 1'b0;
        end
    end

    // forwarding: output stage is oldest, then FIFO head to tail so the newest match wins
    always_comb begin
        fwd_hit1 = 1'b0;
        fwd_hit2 = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx = '0;
        if (RegWrite && reg_live(read_reg1) && write_reg == read_reg1) begin
            fwd_hit1 = 1'b1;
            fwd_data1 = write_data;
        end
        if (RegWrite && reg_live(read_reg2) && write_reg == read_reg2) begin
            fwd_hit2 = 1'b1;
            fwd_data2 = write_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if (CW'(i) < count && reg_live(read_reg1) && regs[idx] == read_reg1) begin
                fwd_hit1 = 1'b1;
                fwd_data1 = datas[idx];
            end
            if (CW'(i) < count && reg_live(read_reg2) && regs[idx] == read_reg2) begin
                fwd_hit2 = 1'b1;
                fwd_data2 = datas[idx];
            end
        end
    end
endmodule
